regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive locked grant cycles for one requester while the other is requesting; legal range 1..255.
REQ-002 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Ports: REQ_A / REQ_B  input  1  access request, requester A / requester B.
REQ-005 Ports: LOCK_A / LOCK_B  input  1  requester asks to keep ownership on following cycles.
REQ-006 Ports: WE_A / WE_B  input  1  write enable for the request.
REQ-007 Ports: DR_A, SR1_A, SR2_A / DR_B, SR1_B, SR2_B  input  5 each  destination and source register numbers.
REQ-008 Ports: WDATA_A / WDATA_B  input  32  write data.
REQ-009 Ports: GNT_A / GNT_B  output  1  combinational grant; a transfer occurs in any cycle where REQ_x and GNT_x are both high.
REQ-010 Ports: RVALID_A / RVALID_B  output  1  read data valid for that requester.
REQ-011 Ports: RDATA1 / RDATA2  output  32  read data, passed through from ReadReg1 / ReadReg2.
REQ-012 Register-file-side ports: RegW  output  1; DR, SR1, SR2  output  5 each; Reg_In  output  32; ReadReg1, ReadReg2  input  32 each.

Function
REQ-013 The state machine SHALL have three states: IDLE, OWN_A, OWN_B.
REQ-014 The block SHALL keep a last-winner pointer LAST (A or B) and a hold counter HOLD, 8 bits wide.
REQ-015 GNT_A and GNT_B SHALL never be high in the same cycle.
REQ-016 Sticky grant: in OWN_x with REQ_x=1, LOCK_x=1, and either other REQ=0 or HOLD<MAX_HOLD, the block SHALL grant x again.
REQ-017 Otherwise, a single requester SHALL win; if both request, the requester that is not LAST SHALL win.
REQ-018 With no requests, GNT_A=GNT_B=0 and the next state SHALL be IDLE.
REQ-019 On a transfer, the next state SHALL be OWN_winner and LAST SHALL be set to the winner.
REQ-020 HOLD SHALL increment on each sticky grant, saturating at 255.
REQ-021 HOLD SHALL clear to 0 on any change of owner and on every cycle without a transfer.
REQ-022 In a transfer cycle, RegW SHALL equal WE of the winner, and DR/SR1/SR2/Reg_In SHALL be the winner's fields.
REQ-023 In a cycle without a transfer, RegW SHALL be 0 and DR/SR1/SR2/Reg_In SHALL be 0.
REQ-024 RVALID_x SHALL be a register set high in the cycle after a transfer by x; it SHALL be high for exactly one cycle per transfer.
REQ-025 Every transfer SHALL issue a read, whether WE is 0 or 1.
REQ-026 Read latency: RDATA returned with RVALID SHALL be the register contents as of the edge that ended the transfer cycle.
REQ-027 Same-cycle write/read of one register by a transfer SHALL return the old value; the block SHALL NOT add bypassing.
REQ-028 Back-to-back transfers SHALL be supported at one per cycle, with no bubble on an owner change.
REQ-029 REQ deasserted while GNT is high SHALL cause no transfer and SHALL leave state unaffected except for the IDLE/HOLD rules above.

Reset
REQ-030 While RST_N=0, the block SHALL force: state IDLE, LAST=B (so A wins the first tie), HOLD=0, RVALID_A=RVALID_B=0.
REQ-031 While RST_N=0, the block SHALL force GNT_A=GNT_B=0, RegW=0, and DR/SR1/SR2/Reg_In=0, asynchronously and independent of CLK.
REQ-032 Reset mid-operation SHALL discard a pending RVALID, and no write SHALL reach the register file while RST_N=0.
REQ-033 After reset release, the first rising edge SHALL follow the normal arbitration rules.

Verification
REQ-034 Tie after reset: REQ_A=REQ_B=1, LOCK=0 for 4 cycles -> grants A,B,A,B; RVALID follows one cycle later each time.
REQ-035 Write then read: A writes 0xDEADBEEF to R5, then reads SR1=5 the next cycle -> RDATA1=0xDEADBEEF with RVALID_A.
REQ-036 Same-cycle write/read: a transfer writes R5 and reads SR1=5 in one cycle -> RDATA1 returns the old value.
REQ-037 Lock fairness: MAX_HOLD=3, LOCK_A=1, both requesting -> A,A,A,A then B; with REQ_B=0, A keeps the grant indefinitely.
REQ-038 Idle: no requests -> RegW=0, GNT=0, no RVALID, and state returns to IDLE.
REQ-039 Async reset during a B write transfer (RST_N low mid-cycle) -> RegW and GNT_B drop immediately, the write is not committed, and RVALID_B stays 0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a register file: combinational grant with
// round-robin tie-break, bounded lock (sticky) ownership, and a registered read-valid.
module regfile_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_A,
    input  logic        REQ_B,
    input  logic        LOCK_A,
    input  logic        LOCK_B,
    input  logic        WE_A,
    input  logic        WE_B,
    input  logic [4:0]  DR_A,
    input  logic [4:0]  SR1_A,
    input  logic [4:0]  SR2_A,
    input  logic [4:0]  DR_B,
    input  logic [4:0]  SR1_B,
    input  logic [4:0]  SR2_B,
    input  logic [31:0] WDATA_A,
    input  logic [31:0] WDATA_B,
    output logic        GNT_A,
    output logic        GNT_B,
    output logic        RVALID_A,
    output logic        RVALID_B,
    output logic [31:0] RDATA1,
    output logic [31:0] RDATA2,
    output logic        RegW,
    output logic [4:0]  DR,
    output logic [4:0]  SR1,
    output logic [4:0]  SR2,
    output logic [31:0] Reg_In,
    input  logic [31:0] ReadReg1,
    input  logic [31:0] ReadReg2
);

    localparam logic [7:0] MAX_HOLD_W = 8'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t     state, state_nxt;
    logic       last_b;
    logic [7:0] hold, hold_nxt;
    logic       sticky_a, sticky_b, win_a, win_b;

    always_comb begin
        sticky_a  = (state == OWN_A) && REQ_A && LOCK_A && (!REQ_B || (hold < MAX_HOLD_W));
        sticky_b  = (state == OWN_B) && REQ_B && LOCK_B && (!REQ_A || (hold < MAX_HOLD_W));
        // On a tie the requester that did not win last time gets the grant.
        win_a     = sticky_a || (!sticky_b && REQ_A && (!REQ_B || last_b));
        win_b     = sticky_b || (!sticky_a && REQ_B && (!REQ_A || !last_b));
        state_nxt = IDLE;
        if (win_a) begin
            state_nxt = OWN_A;
        end else if (win_b) begin
            state_nxt = OWN_B;
        end
        hold_nxt = 8'd0;
        if (sticky_a || sticky_b) begin
            hold_nxt = (hold == 8'hFF) ? hold : hold + 8'd1;
        end
    end

    // Register-file side is forced quiet while reset is held, without waiting for CLK.
    always_comb begin
        GNT_A  = RST_N && win_a;
        GNT_B  = RST_N && win_b;
        RegW   = 1'b0;
        DR     = 5'd0;
        SR1    = 5'd0;
        SR2    = 5'd0;
        Reg_In = 32'd0;
        if (RST_N && win_a) begin
            RegW   = WE_A;
            DR     = DR_A;
            SR1    = SR1_A;
            SR2    = SR2_A;
            Reg_In = WDATA_A;
        end else if (RST_N && win_b) begin
            RegW   = WE_B;
            DR     = DR_B;
            SR1    = SR1_B;
            SR2    = SR2_B;
            Reg_In = WDATA_B;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            hold     <= 8'd0;
            RVALID_A <= 1'b0;
            RVALID_B <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            RVALID_A <= win_a;
            RVALID_B <= win_b;
            if (win_a || win_b) begin
                last_b <= win_b;
            end
        end
    end

    // The register file registers its read addresses, so data lines up with RVALID.
    assign RDATA1 = ReadReg1;
    assign RDATA2 = ReadReg2;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized scoreboard bench for regfile_arbiter with a behavioural arbitration
// and register-file model; read responses are checked by an independent monitor.
module tb_regfile_arbiter;

    localparam int MAXH = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_A = 1'b0, REQ_B = 1'b0, LOCK_A = 1'b0, LOCK_B = 1'b0, WE_A = 1'b0, WE_B = 1'b0;
    logic [4:0]  DR_A = '0, SR1_A = '0, SR2_A = '0, DR_B = '0, SR1_B = '0, SR2_B = '0;
    logic [31:0] WDATA_A = '0, WDATA_B = '0;
    logic        GNT_A, GNT_B, RVALID_A, RVALID_B, RegW;
    logic [31:0] RDATA1, RDATA2, Reg_In, ReadReg1, ReadReg2;
    logic [4:0]  DR, SR1, SR2;

    always #5 CLK = ~CLK;

    regfile_arbiter #(.MAX_HOLD(MAXH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .LOCK_A(LOCK_A), .LOCK_B(LOCK_B),
        .WE_A(WE_A), .WE_B(WE_B),
        .DR_A(DR_A), .SR1_A(SR1_A), .SR2_A(SR2_A),
        .DR_B(DR_B), .SR1_B(SR1_B), .SR2_B(SR2_B),
        .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .RVALID_A(RVALID_A), .RVALID_B(RVALID_B),
        .RDATA1(RDATA1), .RDATA2(RDATA2),
        .RegW(RegW), .DR(DR), .SR1(SR1), .SR2(SR2), .Reg_In(Reg_In),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2)
    );

    function automatic logic [31:0] init_val(int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Register file environment: synchronous read of the presented addresses, old value on collision.
    logic [31:0] rf [32];
    logic [31:0] rd1 = '0, rd2 = '0;
    logic        init_req = 1'b1;
    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else begin
            rd1 <= rf[SR1];
            rd2 <= rf[SR2];
            if (RegW) rf[DR] <= Reg_In;
        end
    end
    assign ReadReg1 = rd1;
    assign ReadReg2 = rd2;

    typedef struct packed {
        logic        req;
        logic        lock;
        logic        we;
        logic [4:0]  dr;
        logic [4:0]  sr1;
        logic [4:0]  sr2;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        bit          who_b;
        logic [31:0] d1;
        logic [31:0] d2;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          m_owner, m_last, m_hold;
    logic [31:0] m_rf [32];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(bit rq, bit lk, bit we, int dr, int s1, int s2, logic [31:0] wd);
        req_t r;
        r.req = rq; r.lock = lk; r.we = we;
        r.dr = 5'(dr); r.sr1 = 5'(s1); r.sr2 = 5'(s2); r.wd = wd;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
    endfunction

    task automatic apply(req_t a, req_t b);
        REQ_A = a.req; LOCK_A = a.lock; WE_A = a.we; DR_A = a.dr; SR1_A = a.sr1; SR2_A = a.sr2; WDATA_A = a.wd;
        REQ_B = b.req; LOCK_B = b.lock; WE_B = b.we; DR_B = b.dr; SR1_B = b.sr1; SR2_B = b.sr2; WDATA_B = b.wd;
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_hold = 0;
    endtask

    // One arbitration cycle: drive, predict winner from the rules, check ports, queue the read.
    task automatic do_cycle(req_t a, req_t b);
        int   w;
        bit   sticky;
        req_t wr;
        exp_t e;
        @(negedge CLK);
        apply(a, b);
        #1;
        sticky = (m_owner == 1 && a.req && a.lock && (!b.req || m_hold < MAXH)) ||
                 (m_owner == 2 && b.req && b.lock && (!a.req || m_hold < MAXH));
        if (sticky)                 w = m_owner;
        else if (a.req && b.req)    w = 3 - m_last;
        else if (a.req)             w = 1;
        else if (b.req)             w = 2;
        else                        w = 0;
        wr = (w == 1) ? a : (w == 2) ? b : '0;
        chk("gnt", 64'({GNT_A, GNT_B}), 64'({w == 1, w == 2}));
        chk("rf_port", 64'({RegW, DR, SR1, SR2, Reg_In}), 64'({wr.we, wr.dr, wr.sr1, wr.sr2, wr.wd}));
        if (w != 0) begin
            e.who_b = (w == 2);
            e.d1    = m_rf[wr.sr1];
            e.d2    = m_rf[wr.sr2];
            e.due   = cyc + 1;
            sbq.push_back(e);
            if (wr.we) m_rf[wr.dr] = wr.wd;
            m_hold  = sticky ? ((m_hold == 255) ? 255 : m_hold + 1) : 0;
            m_owner = w;
            m_last  = w;
        end else begin
            m_owner = 0;
            m_hold  = 0;
        end
    endtask

    // Monitor: pairs each RVALID with the oldest outstanding expected read.
    exp_t me;
    always @(posedge CLK) begin
        cyc++;
        #2;
        if (RVALID_A || RVALID_B) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rvalid", 64'({RVALID_A, RVALID_B}), 64'd0);
            end else begin
                me = sbq.pop_front();
                chk("rvalid_who", 64'({RVALID_A, RVALID_B}), 64'({!me.who_b, me.who_b}));
                chk("rvalid_cycle", 64'(cyc), 64'(me.due));
                chk("rdata", {RDATA1, RDATA2}, {me.d1, me.d2});
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            me = sbq.pop_front();
            chk("missing_rvalid", 64'({RVALID_A, RVALID_B}), 64'({!me.who_b, me.who_b}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t idle, a_lock, b_req, bw;
        idle = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = init_val(i);
        model_reset();

        // Reset held with live requests: outputs must stay forced low.
        apply(mk(1, 1, 1, 3, 4, 5, 32'h1111_2222), mk(1, 1, 1, 6, 7, 8, 32'h3333_4444));
        repeat (2) @(posedge CLK);
        #1;
        chk("gnt_in_reset", 64'({GNT_A, GNT_B}), 64'd0);
        chk("port_in_reset", 64'({RegW, DR, SR1, SR2, Reg_In}), 64'd0);
        chk("rvalid_in_reset", 64'({RVALID_A, RVALID_B}), 64'd0);
        @(negedge CLK);
        apply(idle, idle);
        RST_N = 1'b1;
        init_req = 1'b0;

        // Tie after reset: A, B, A, B.
        for (int i = 0; i < 4; i++) do_cycle(mk(1, 0, 0, 0, i, i + 8, 0), mk(1, 0, 0, 0, i + 16, i + 24, 0));

        // Write then read, then same-cycle write/read returning the old value.
        do_cycle(mk(1, 0, 1, 5, 1, 2, 32'hDEAD_BEEF), idle);
        do_cycle(mk(1, 0, 0, 0, 5, 6, 0), idle);
        do_cycle(mk(1, 0, 1, 5, 5, 5, 32'hCAFE_F00D), idle);
        do_cycle(mk(1, 0, 0, 0, 5, 5, 0), idle);

        // Lock fairness: B owns, then A locked vs B: A,A,A,A,B,A; then A alone holds; then B wins.
        a_lock = mk(1, 1, 0, 0, 10, 11, 0);
        b_req  = mk(1, 0, 0, 0, 12, 13, 0);
        do_cycle(idle, b_req);
        for (int i = 0; i < 6; i++) do_cycle(a_lock, b_req);
        for (int i = 0; i < 20; i++) do_cycle(a_lock, idle);
        do_cycle(a_lock, b_req);

        // Idle cycles, with and without a back-to-back owner change before them.
        for (int i = 0; i < 3; i++) do_cycle(idle, idle);
        do_cycle(mk(1, 1, 0, 0, 1, 1, 0), idle);

        // Asynchronous reset in the middle of a B write transfer.
        do_cycle(idle, idle);
        @(negedge CLK);
        bw = mk(1, 0, 1, 9, 3, 4, 32'h1234_5678);
        apply(idle, bw);
        #1;
        chk("gnt_b_before_rst", 64'({GNT_A, GNT_B}), 64'b01);
        chk("regw_before_rst", 64'(RegW), 64'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("gnt_async_rst", 64'({GNT_A, GNT_B}), 64'd0);
        chk("port_async_rst", 64'({RegW, DR, SR1, SR2, Reg_In}), 64'd0);
        @(posedge CLK);
        #1;
        chk("rvalid_after_rst", 64'({RVALID_A, RVALID_B}), 64'd0);
        @(negedge CLK);
        apply(idle, idle);
        RST_N = 1'b1;
        model_reset();
        sbq.delete();
        do_cycle(mk(1, 0, 0, 0, 9, 9, 0), idle);
        // A tie straight after release must go to A again.
        do_cycle(mk(1, 0, 0, 0, 2, 3, 0), mk(1, 0, 0, 0, 4, 5, 0));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) do_cycle(rnd_req(), rnd_req());

        for (int i = 0; i < 3; i++) do_cycle(idle, idle);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
